// File: rtl/usart_rx_deframer.sv
// 8N1 UART receive deframer: 2-flop synchronizer, mid-bit sampling FSM, byte FIFO.
// Define USART_RX_PARITY_EN to add an even-parity bit between d7 and stop (11-bit frames).
module usart_rx_deframer #(
    parameter int CLOCKS_PER_BIT = 868,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_sync;
    logic            w_rx_s;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            w_cnt_clr, w_sample, w_push, w_ferr;
    logic            r_ferr, r_ovr;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_pop, w_full, w_wr, w_ovr;

    // rx is asynchronous to clk; two flops before anything looks at it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= 2'b11;
        else       r_sync <= {r_sync[0], rx};
    end
    assign w_rx_s = r_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

`ifdef USART_RX_PARITY_EN
    logic w_perr, r_perr;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_sample    = 1'b0;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
`ifdef USART_RX_PARITY_EN
        w_perr      = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!w_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                // mid start bit: a line back high here was only a glitch
                if (r_cnt == HALF_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_clr = 1'b1;
                    w_sample  = 1'b1;
                    if (r_idx == 3'd7) begin
`ifdef USART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef USART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_clr   = 1'b1;
                    w_perr      = (w_rx_s != ^r_shift);
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_clr = 1'b1;
                    if (w_rx_s) begin
                        w_push      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_clr = 1'b1;
                if (w_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_cnt <= '0;
        else if (w_cnt_clr) r_cnt <= '0;
        else                r_cnt <= r_cnt + CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            if (r_state != S_DATA) r_idx <= 3'd0;
            else if (w_sample)     r_idx <= r_idx + 3'd1;
            if (w_sample) r_shift[r_idx] <= w_rx_s;
        end
    end

    // FIFO: a push into a full FIFO only lands if the head leaves the same cycle
    assign w_pop  = rx_valid && rx_ready;
    assign w_full = (r_count == FULL_CNT);
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_ovr  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign rx_valid = (r_count != '0);
    assign rx_data  = rx_valid ? r_mem[r_rd_ptr] : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= w_ovr;
        end
    end
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

`ifdef USART_RX_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_perr <= 1'b0;
        else       r_perr <= w_perr;
    end
    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_usart_rx_deframer.sv
// Randomized bench for usart_rx_deframer: byte/error expectations come from a queue model of
// what each transmitted frame must produce, checked every cycle by one compare process.
module tb_usart_rx_deframer;
    localparam int CPB   = 16;
    localparam int DEPTH = 16;
`ifdef USART_RX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif
    // rx falls, +3 edges to start detect, then half a bit plus 9 (or 10) bit periods to stop sample
    localparam int LAT = 3 + CPB/2 + (9 + PAR_EN)*CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun;

    usart_rx_deframer #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0, n_pop = 0;
    int exp_ferr = 0, exp_perr = 0, exp_ovr = 0;
    logic [7:0] q[$];
    bit rnd_rdy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // model of the receive FIFO as seen from the frame level
    task automatic expect_frame(input logic [7:0] b, input bit stop_ok, input bit par_flip);
        if (PAR_EN != 0 && par_flip) exp_perr++;
        if (!stop_ok)               exp_ferr++;
        else if (q.size() >= DEPTH) exp_ovr++;
        else                        q.push_back(b);
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) begin
            if (rnd_rdy) rx_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stopv, input bit par_flip);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        if (PAR_EN != 0) hold(^b ^ par_flip, CPB);
        hold(stopv, CPB);
    endtask

    task automatic send(input logic [7:0] b, input bit par_flip);
        expect_frame(b, 1'b1, par_flip);
        drive_frame(b, 1'b1, par_flip);
    endtask

    task automatic settle();
        int t = 0;
        rnd_rdy  = 1'b0;
        rx_ready = 1'b1;
        while ((q.size() != 0 || rx_valid) && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        repeat (4) begin @(posedge clk); #1; end
        chk("drain_bound", int'(t < 2000), 1);
        chk("fifo_empty", int'(rx_valid), 0);
        chk("bytes_missing", q.size(), 0);
        chk("ferr_missing", exp_ferr, 0);
        chk("perr_missing", exp_perr, 0);
        chk("ovr_missing", exp_ovr, 0);
    endtask

    // compare process: every handshake and every error pulse must be one the model predicted
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid && rx_ready) begin
                n_pop++;
                if (q.size() == 0) chk("unexpected_byte", int'(rx_data), -1);
                else               chk("rx_data", int'(rx_data), int'(q.pop_front()));
            end
            if (frame_err) begin
                if (exp_ferr == 0) chk("extra_frame_err", 1, 0);
                else begin exp_ferr--; n_vec++; end
            end
            if (parity_err) begin
                if (exp_perr == 0) chk("extra_parity_err", 1, 0);
                else begin exp_perr--; n_vec++; end
            end
            if (overrun) begin
                if (exp_ovr == 0) chk("extra_overrun", 1, 0);
                else begin exp_ovr--; n_vec++; end
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_errs", int'({frame_err, parity_err, overrun}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        hold(1'b1, 8);

        // two clean frames, with the push latency pinned on the first
        rx_ready = 1'b1;
        expect_frame(8'h55, 1'b1, 1'b0);
        lat = 0;
        fork
            drive_frame(8'h55, 1'b1, 1'b0);
            begin
                while (lat < LAT + 20) begin
                    @(posedge clk); lat++;
                    @(negedge clk);
                    if (rx_valid) break;
                end
            end
        join
        chk("push_latency", lat, LAT);
        send(8'hA3, 1'b0);
        hold(1'b1, 4);
        settle();
        chk("two_handshakes", n_pop, 2);

        // short low glitch is a false start
        hold(1'b0, 5);
        hold(1'b1, 3*CPB);
        settle();

        // bad stop, line held low, then a good frame
        expect_frame(8'h0F, 1'b0, 1'b0);
        drive_frame(8'h0F, 1'b0, 1'b0);
        hold(1'b0, 40);
        hold(1'b1, 8);
        send(8'h81, 1'b0);
        hold(1'b1, 4);
        settle();

        // overflow: 17 bytes with the consumer stalled
        rx_ready = 1'b0;
        for (int i = 0; i <= 16; i++) send(8'(i), 1'b0);
        hold(1'b1, 4);
        chk("full_valid", int'(rx_valid), 1);
        chk("full_head", int'(rx_data), 8'h00);
        chk("model_depth", q.size(), DEPTH);
        settle();

        // reset mid-frame flushes a stored byte and the partial one
        rx_ready = 1'b0;
        send(8'h11, 1'b0);
        fork
            drive_frame(8'hFF, 1'b1, 1'b0);
            begin
                repeat (5*CPB + CPB/2) @(posedge clk);
                #2 reset = 1'b1;
                q.delete();
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("midrst_valid", int'(rx_valid), 0);
                chk("midrst_data", int'(rx_data), 0);
                @(posedge clk);
                #2 reset = 1'b0;
            end
        join
        hold(1'b1, 4);
        chk("post_rst_empty", int'(rx_valid), 0);
        send(8'h3C, 1'b0);
        hold(1'b1, 4);
        settle();

`ifdef USART_RX_PARITY_EN
        send(8'h07, 1'b1);
        hold(1'b1, 4);
        settle();
        send(8'h07, 1'b0);
        hold(1'b1, 4);
        settle();
`endif

        // randomized traffic with a randomly stalling consumer
        for (int n = 0; n < 40; n++) begin
            int  kind;
            bit  flip;
            logic [7:0] b;
            kind = int'($urandom_range(0, 9));
            b    = 8'($urandom);
            flip = (PAR_EN != 0) && ($urandom_range(0, 3) == 0);
            rnd_rdy = 1'b1;
            if (kind == 0) begin
                hold(1'b0, int'($urandom_range(1, 6)));
                hold(1'b1, 2*CPB);
            end else if (kind == 1) begin
                expect_frame(b, 1'b0, flip);
                drive_frame(b, 1'b0, flip);
                hold(1'b0, int'($urandom_range(0, 40)));
                hold(1'b1, int'($urandom_range(4, 12)));
            end else begin
                send(b, flip);
                hold(1'b1, int'($urandom_range(1, 12)));
            end
        end
        settle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
